// File: rtl/mult_div_sequencer.sv
// mult_div_sequencer: command front-end for the 16/32-bit multiply/divide
// engine. Operand commands are queued in a small FIFO and issued one at a
// time over the engine's level go/done handshake. Each 32-bit result (or an
// error result for divide-by-zero / timeout) is returned on a valid/ready
// result port.
//
// Handshakes:
//   cmd : a command transfers on a rising edge where i_cmd_valid && o_cmd_ready.
//         o_cmd_ready depends only on the registered FIFO count and i_reset.
//   res : a result transfers on a rising edge where o_res_valid && i_res_ready.
//         o_res_data/o_res_op/o_res_err are stable while o_res_valid is high.
//   eng : o_go is a registered level. The engine raises i_done when
//         i_sal_32 is valid. go drops after done is seen, and the next command
//         is not issued until done has returned low. Operands are held stable
//         from the issuing edge until the next pop.
module mult_div_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic        i_cmd_op,
  input  logic [31:0] i_cmd_a,
  input  logic [15:0] i_cmd_b,
  output logic        o_res_valid,
  input  logic        i_res_ready,
  output logic [31:0] o_res_data,
  output logic        o_res_op,
  output logic        o_res_err,
  output logic        o_go,
  output logic        o_div_mult,
  output logic [31:0] o_ent_32,
  output logic [15:0] o_ent_16,
  input  logic        i_done,
  input  logic [31:0] i_sal_32,
  output logic [1:0]  o_state
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;
  localparam logic [1:0] S_OUTPUT  = 2'd3;

  // FIFO storage: {op, a[31:0], b[15:0]}
  logic [48:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic [1:0]    r_state;
  logic          r_go;
  logic          r_op;
  logic [31:0]   r_a;
  logic [15:0]   r_b;
  logic [31:0]   r_res_data;
  logic          r_res_err;
  logic [CW-1:0] r_cnt;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [48:0]   w_head;
  logic          w_head_op;
  logic [31:0]   w_head_a;
  logic [15:0]   w_head_b;

  assign w_full    = (r_count == DEPTH_CNT);
  assign w_empty   = (r_count == '0);
  assign w_push    = i_cmd_valid && o_cmd_ready;
  assign w_pop     = (r_state == S_IDLE) && !w_empty;
  assign w_head    = r_mem[r_rd_ptr];
  assign w_head_op = w_head[48];
  assign w_head_a  = w_head[47:16];
  assign w_head_b  = w_head[15:0];

  // FIFO data array write; contents are don't-care until pushed
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {i_cmd_op, i_cmd_a, i_cmd_b};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth)
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Issue FSM: pop, drive engine, capture result or error, present result
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_go       <= 1'b0;
      r_op       <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_res_data <= '0;
      r_res_err  <= 1'b0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_op  <= w_head_op;
            r_a   <= w_head_a;
            r_b   <= w_head_b;
            r_cnt <= '0;
            if (!w_head_op && (w_head_b == 16'd0)) begin
              // divide-by-zero never reaches the engine
              r_res_data <= '0;
              r_res_err  <= 1'b1;
              r_state    <= S_OUTPUT;
            end else begin
              r_go    <= 1'b1;
              r_state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (i_done) begin
            // completion wins over a timeout landing on the same edge
            r_res_data <= i_sal_32;
            r_res_err  <= 1'b0;
            r_go       <= 1'b0;
            r_state    <= S_RELEASE;
          end else if (r_cnt == TO_LAST) begin
            r_res_data <= '0;
            r_res_err  <= 1'b1;
            r_go       <= 1'b0;
            r_state    <= S_RELEASE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RELEASE: begin
          if (!i_done) r_state <= S_OUTPUT;
        end
        S_OUTPUT: begin
          if (i_res_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_cmd_ready = !w_full && !i_reset;
  assign o_res_valid = (r_state == S_OUTPUT);
  assign o_res_data  = r_res_data;
  assign o_res_op    = r_op;
  assign o_res_err   = r_res_err;
  assign o_go        = r_go;
  assign o_div_mult  = r_op;
  assign o_ent_32    = r_a;
  assign o_ent_16    = r_b;
  assign o_state     = r_state;

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Directed testbench for mult_div_sequencer with a behavioural engine model
// (fixed latency, optional stall) and an expected-result queue.
module tb_mult_div_sequencer;

  localparam int LAT = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_op;
  logic [31:0] cmd_a;
  logic [15:0] cmd_b;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_op;
  logic        res_err;
  logic        go;
  logic        div_mult;
  logic [31:0] ent_32;
  logic [15:0] ent_16;
  logic        done;
  logic [31:0] sal_32;
  logic [1:0]  state;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  logic        exp_op_q[$];

  mult_div_sequencer #(.FIFO_DEPTH(4), .TIMEOUT(8)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_op(cmd_op), .i_cmd_a(cmd_a), .i_cmd_b(cmd_b),
    .o_res_valid(res_valid), .i_res_ready(res_ready),
    .o_res_data(res_data), .o_res_op(res_op), .o_res_err(res_err),
    .o_go(go), .o_div_mult(div_mult), .o_ent_32(ent_32), .o_ent_16(ent_16),
    .i_done(done), .i_sal_32(sal_32), .o_state(state)
  );

  // clock
  always #5 clk = ~clk;

  // engine model: done rises so that go is seen high for LAT cycles
  logic        stall = 1'b0;
  int          ecnt  = 0;
  logic signed [31:0] sa, sb;
  always @(posedge clk) begin
    if (!go) begin
      ecnt <= 0;
      done <= 1'b0;
    end else if (!stall && !done) begin
      if (ecnt == LAT - 2) begin
        done <= 1'b1;
        if (div_mult) begin
          sal_32 <= ent_32 * {16'd0, ent_16};
        end else begin
          sa = ent_32;
          sb = {{16{ent_16[15]}}, ent_16};
          sal_32 <= sa / sb;
        end
      end else begin
        ecnt <= ecnt + 1;
      end
    end
  end

  // go monitor: run length, rising edges, operand stability while go=1
  int          go_run = 0, last_go_len = 0, go_rises = 0, stab_err = 0;
  logic        prev_go = 1'b0, p_dm = 1'b0;
  logic [31:0] p32 = '0;
  logic [15:0] p16 = '0;
  always @(negedge clk) begin
    if (go) begin
      go_run = go_run + 1;
      if (go_run > 1 && (ent_32 != p32 || ent_16 != p16 || div_mult != p_dm))
        stab_err = stab_err + 1;
    end else if (go_run != 0) begin
      last_go_len = go_run;
      go_run = 0;
    end
    if (go && !prev_go) go_rises = go_rises + 1;
    prev_go = go; p32 = ent_32; p16 = ent_16; p_dm = div_mult;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // called at a negedge; offers one command for one edge, returns at next negedge
  task automatic push_try(input logic op, input logic [31:0] a, input logic [15:0] b,
                          output logic acc);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    acc = cmd_ready;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // waits (bounded) for a result, checks it, accepts it
  task automatic take_result(input string tag, input logic [31:0] ed,
                             input logic eo, input logic ee);
    int n = 0;
    while (res_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (res_valid === 1'b1) else begin
      failures++;
      $error("FAIL %s_wait observed=res_valid %b expected=1 within 100 cycles", tag, res_valid);
    end
    check({tag, "_data"}, res_data, ed);
    check({tag, "_op"}, {31'd0, res_op}, {31'd0, eo});
    check({tag, "_err"}, {31'd0, res_err}, {31'd0, ee});
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, "_clr"}, {31'd0, res_valid}, 32'd0);
  endtask

  logic        acc;
  int          rises0;
  logic [31:0] va [5];
  logic [15:0] vb [5];
  logic        vo [5];
  logic [31:0] vr [5];
  logic        vacc [5];

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_a = '0; cmd_b = '0;
    res_ready = 1'b0; done = 1'b0; sal_32 = '0;

    // ---- reset state
    #1;
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    repeat (3) @(negedge clk);
    check("rst_go", {31'd0, go}, 32'd0);
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_res_data", res_data, 32'd0);
    check("rst_ent_32", ent_32, 32'd0);
    check("rst_state", {30'd0, state}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // ---- multiply 7 x 3, engine latency 5
    push_try(1'b1, 32'h0000_0007, 16'h0003, acc);
    check("mul_acc", {31'd0, acc}, 32'd1);
    check("mul_no_bypass_go", {31'd0, go}, 32'd0);
    @(negedge clk);
    check("mul_go_lat", {31'd0, go}, 32'd1);
    check("mul_ent32", ent_32, 32'h0000_0007);
    check("mul_ent16", {16'd0, ent_16}, 32'h0000_0003);
    check("mul_divmult", {31'd0, div_mult}, 32'd1);
    take_result("mul7x3", 32'h0000_0015, 1'b1, 1'b0);
    check("mul_go_len", last_go_len, 32'd5);

    // ---- signed divide -100 / 7
    push_try(1'b0, 32'hFFFF_FF9C, 16'h0007, acc);
    take_result("div_neg", 32'hFFFF_FFF2, 1'b0, 1'b0);

    // ---- divide by zero: engine skipped
    rises0 = go_rises;
    push_try(1'b0, 32'h0000_1234, 16'h0000, acc);
    @(negedge clk);
    check("div0_valid_lat", {31'd0, res_valid}, 32'd1);
    check("div0_go", {31'd0, go}, 32'd0);
    take_result("div0", 32'd0, 1'b0, 1'b1);
    @(negedge clk);
    check("div0_no_go_rise", go_rises, rises0);

    // ---- FIFO fill with result port stalled
    push_try(1'b0, 32'h0000_0055, 16'h0000, acc);   // parks a result in OUTPUT
    @(negedge clk);
    check("fill_park_state", {30'd0, state}, 32'd3);
    va[0] = 32'h0000_0002;  vb[0] = 16'h0003; vo[0] = 1'b1; vr[0] = 32'h0000_0006;  vacc[0] = 1'b1;
    va[1] = 32'h0001_0000;  vb[1] = 16'h0010; vo[1] = 1'b1; vr[1] = 32'h0010_0000;  vacc[1] = 1'b1;
    va[2] = 32'h0000_0064;  vb[2] = 16'h0005; vo[2] = 1'b0; vr[2] = 32'h0000_0014;  vacc[2] = 1'b1;
    va[3] = 32'h0000_FFFF;  vb[3] = 16'h0002; vo[3] = 1'b1; vr[3] = 32'h0001_FFFE;  vacc[3] = 1'b1;
    va[4] = 32'h0000_0009;  vb[4] = 16'h0009; vo[4] = 1'b1; vr[4] = 32'h0000_0051;  vacc[4] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push_try(vo[i], va[i], vb[i], acc);
      check($sformatf("fill_acc%0d", i), {31'd0, acc}, {31'd0, vacc[i]});
      if (acc) begin
        exp_q.push_back(vr[i]);
        exp_op_q.push_back(vo[i]);
      end
    end
    check("fill_full_ready", {31'd0, cmd_ready}, 32'd0);
    take_result("fill_park", 32'd0, 1'b0, 1'b1);
    check("fill_ready_before_pop", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    check("fill_ready_after_pop", {31'd0, cmd_ready}, 32'd1);
    while (exp_q.size() > 0) begin
      take_result("fill_res", exp_q.pop_front(), exp_op_q.pop_front(), 1'b0);
    end
    check("fill_stability", stab_err, 32'd0);

    // ---- timeout with stalled engine, then normal recovery
    stall = 1'b1;
    push_try(1'b1, 32'h0000_0009, 16'h0009, acc);
    @(negedge clk);
    check("to_go", {31'd0, go}, 32'd1);
    take_result("timeout", 32'd0, 1'b1, 1'b1);
    check("to_go_len", last_go_len, 32'd8);
    stall = 1'b0;
    push_try(1'b1, 32'h0000_0004, 16'h0005, acc);
    take_result("after_to", 32'h0000_0014, 1'b1, 1'b0);

    // ---- reset during ISSUE with two queued
    push_try(1'b1, 32'h0000_0001, 16'h0001, acc);
    push_try(1'b1, 32'h0000_0002, 16'h0002, acc);
    push_try(1'b1, 32'h0000_0003, 16'h0003, acc);
    @(negedge clk);
    check("mid_rst_go_before", {31'd0, go}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_go", {31'd0, go}, 32'd0);
    check("mid_rst_ready", {31'd0, cmd_ready}, 32'd0);
    check("mid_rst_state", {30'd0, state}, 32'd0);
    check("mid_rst_ent32", ent_32, 32'd0);
    @(negedge clk);
    check("mid_rst_done_low", {31'd0, done}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    check("post_mid_rst_go", {31'd0, go}, 32'd0);
    check("post_mid_rst_valid", {31'd0, res_valid}, 32'd0);
    push_try(1'b1, 32'h0000_0006, 16'h0007, acc);
    check("rec_no_bypass", {31'd0, go}, 32'd0);
    @(negedge clk);
    check("rec_go_lat", {31'd0, go}, 32'd1);
    take_result("recover", 32'h0000_002A, 1'b1, 1'b0);
    check("rec_go_len", last_go_len, 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
